// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the memory stage: control struct, LSU state enum,
// funct3 encodings and the store-side lane helpers.
package cpu_types;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
  } ctrl_t;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // 0 = byte, 1 = half, 2 = word; unused encodings fall into word.
  function automatic logic [1:0] access_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   access_size = 2'd0;
      2'b01:   access_size = 2'd1;
      default: access_size = 2'd2;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] offset);
    case (access_size(funct3))
      2'd0:    is_misaligned = 1'b0;
      2'd1:    is_misaligned = offset[0];
      default: is_misaligned = (offset != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [2:0] funct3, input logic [1:0] offset);
    case (access_size(funct3))
      2'd0:    byte_enables = 4'b0001 << offset;
      2'd1:    byte_enables = offset[1] ? 4'b1100 : 4'b0011;
      default: byte_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_replicate(input logic [2:0] funct3, input logic [31:0] data);
    case (access_size(funct3))
      2'd0:    lane_replicate = {4{data[7:0]}};
      2'd1:    lane_replicate = {2{data[15:0]}};
      default: lane_replicate = data;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension of the raw bus word.
module load_extend
  import cpu_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the addressed lane, then extend according to the load flavour.
  always_comb begin
    case (addr)
      2'b00:   byte_lane = rdata[7:0];
      2'b01:   byte_lane = rdata[15:8];
      2'b10:   byte_lane = rdata[23:16];
      default: byte_lane = rdata[31:24];
    endcase
    half_lane = addr[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      LB:      data = {{24{byte_lane[7]}}, byte_lane};
      LH:      data = {{16{half_lane[15]}}, half_lane};
      LBU:     data = {24'd0, byte_lane};
      LHU:     data = {16'd0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: drives a req/gnt/rvalid data bus, stalls the
// pipeline while a transaction is outstanding and aborts after MAX_WAIT cycles.
module load_store_unit
  import cpu_types::*;
#(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  ctrl_t       mem_ctrl,
  input  logic [31:0] mem_alu_out,
  input  logic [31:0] mem_store_data,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  output logic [31:0] load_data,
  output logic        mem_stall,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam int CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
  localparam logic [CW-1:0] LAST_WAIT = CW'(MAX_WAIT - 1);

  lsu_state_t  state, next_state;
  logic [CW-1:0] wait_cnt;
  logic        capture, load_done;
  logic        access, misaligned;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_be;
  logic [2:0]  cap_funct3;
  logic        cap_we;
  logic [31:0] ext_data;

  assign access     = mem_ctrl.mem_read | mem_ctrl.mem_write;
  assign misaligned = is_misaligned(mem_ctrl.mem_funct3, mem_alu_out[1:0]);

  load_extend u_load_extend (
    .funct3 (cap_funct3),
    .addr   (cap_addr[1:0]),
    .rdata  (dbus_rdata),
    .data   (ext_data)
  );

  // Bus drive, stall and next-state decode; completion wins over timeout.
  always_comb begin
    next_state   = state;
    dbus_req     = 1'b0;
    dbus_we      = 1'b0;
    dbus_addr    = 32'd0;
    dbus_be      = 4'd0;
    dbus_wdata   = 32'd0;
    mem_stall    = 1'b0;
    misalign_err = 1'b0;
    bus_err      = 1'b0;
    capture      = 1'b0;
    load_done    = 1'b0;
    case (state)
      LSU_IDLE: begin
        if (access && misaligned) begin
          misalign_err = 1'b1;
        end else if (access) begin
          dbus_req   = 1'b1;
          dbus_we    = mem_ctrl.mem_write;
          dbus_addr  = {mem_alu_out[31:2], 2'b00};
          dbus_be    = byte_enables(mem_ctrl.mem_funct3, mem_alu_out[1:0]);
          dbus_wdata = mem_ctrl.mem_write ?
                       lane_replicate(mem_ctrl.mem_funct3, mem_store_data) : 32'd0;
          capture    = 1'b1;
          if (dbus_gnt && mem_ctrl.mem_write) begin
            next_state = LSU_IDLE;
          end else if (dbus_gnt) begin
            next_state = LSU_RESP;
            mem_stall  = 1'b1;
          end else begin
            next_state = LSU_REQ;
            mem_stall  = 1'b1;
          end
        end else begin
          next_state = LSU_IDLE;
        end
      end
      LSU_REQ: begin
        dbus_req   = 1'b1;
        dbus_we    = cap_we;
        dbus_addr  = {cap_addr[31:2], 2'b00};
        dbus_be    = cap_be;
        dbus_wdata = cap_wdata;
        if (dbus_gnt) begin
          next_state = cap_we ? LSU_IDLE : LSU_RESP;
          mem_stall  = ~cap_we;
        end else if (wait_cnt == LAST_WAIT) begin
          next_state = LSU_IDLE;
          bus_err    = 1'b1;
        end else begin
          mem_stall  = 1'b1;
        end
      end
      LSU_RESP: begin
        if (dbus_rvalid) begin
          next_state = LSU_IDLE;
          load_done  = 1'b1;
        end else if (wait_cnt == LAST_WAIT) begin
          next_state = LSU_IDLE;
          bus_err    = 1'b1;
        end else begin
          mem_stall  = 1'b1;
        end
      end
      default: begin
        next_state = LSU_IDLE;
      end
    endcase
    load_data = load_done ? ext_data : 32'd0;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LSU_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Wait counter: restarts whenever a waiting state is entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if ((next_state != state) && (next_state != LSU_IDLE)) begin
      wait_cnt <= '0;
    end else if (state != LSU_IDLE) begin
      wait_cnt <= wait_cnt + CW'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  // Request fields are frozen at issue so the bus sees them stable in REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      cap_be     <= 4'd0;
      cap_funct3 <= 3'd0;
      cap_we     <= 1'b0;
    end else if (capture) begin
      cap_addr   <= mem_alu_out;
      cap_wdata  <= dbus_wdata;
      cap_be     <= dbus_be;
      cap_funct3 <= mem_ctrl.mem_funct3;
      cap_we     <= mem_ctrl.mem_write;
    end else begin
      cap_addr   <= cap_addr;
      cap_wdata  <= cap_wdata;
      cap_be     <= cap_be;
      cap_funct3 <= cap_funct3;
      cap_we     <= cap_we;
    end
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MAX_WAIT, default 255: bus wait cycles before an access is aborted with bus_err.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 mem_ctrl  in  ctrl_t  MEM-stage control; fields used: mem_read, mem_write, mem_funct3[2:0].
REQ-005 mem_alu_out  in  32  effective byte address.
REQ-006 mem_store_data  in  32  store source (rs2 value).
REQ-007 dbus_req / dbus_we  out  1 / 1  request valid / write enable.
REQ-008 dbus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-009 dbus_be / dbus_wdata  out  4 / 32  byte enables / lane-replicated write data.
REQ-010 dbus_gnt  in  1  request accepted this cycle.
REQ-011 dbus_rvalid / dbus_rdata  in  1 / 32  read response valid / data.
REQ-012 load_data  out  32  extended load result, valid in the completion cycle.
REQ-013 mem_stall  out  1  freeze PC..EX/MEM and bubble MEM/WB while high.
REQ-014 misalign_err / bus_err  out  1 / 1  one-cycle error pulses.

Function
REQ-015 Access = mem_read|mem_write; when both are high, mem_write wins.
REQ-016 Misaligned = halfword with addr[0]=1, or word with addr[1:0]!=0; misaligned accesses issue no bus request, pulse misalign_err combinationally for that cycle, mem_stall=0, and load_data=0.
REQ-017 States: IDLE, REQ (waiting dbus_gnt), RESP (waiting dbus_rvalid).
REQ-018 IDLE with an aligned access: dbus_req=1 combinationally from the inputs; the request fields are captured into internal registers at the same edge.
REQ-019 IDLE with gnt: a store completes that cycle (no stall), and a load moves to RESP; without gnt, move to REQ.
REQ-020 REQ: drive the captured request fields and hold them stable; on gnt, a store returns to IDLE and a load moves to RESP.
REQ-021 RESP: dbus_req=0; on dbus_rvalid, load_data=extend(dbus_rdata) in that cycle and the next state is IDLE.
REQ-022 mem_stall = (aligned access and not completing this cycle) in IDLE, and 1 in REQ/RESP except in the completion or abort cycle.
REQ-023 Earliest load completion is the cycle after gnt, so a load costs at least one stall cycle; a granted zero-wait store costs none.
REQ-024 Store byte enables: SB 0001<<addr[1:0]; SH 0011 or 1100 per addr[1]; SW 1111.
REQ-025 Store write data: SB byte replicated x4; SH half replicated x2; SW unchanged.
REQ-026 Loads: select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through; unused funct3 values are treated as LW.
REQ-027 A wait counter clears on entry to REQ/RESP and increments each cycle in REQ/RESP.
REQ-028 When the counter reaches MAX_WAIT: pulse bus_err, set load_data=0, return to IDLE, and drop mem_stall that cycle.
REQ-029 dbus_rvalid in IDLE or REQ is ignored; dbus_gnt in RESP is ignored.
REQ-030 load_data=0 in every cycle that is not a load completion.

Reset
REQ-031 Reset yields: state IDLE, counter 0, captured registers 0, and bus outputs 0 while no access is presented.
REQ-032 Reset in REQ/RESP abandons the transaction without an error pulse; a late rvalid after reset is ignored per REQ-029.

Structure
REQ-033 The lsu_state_t enum and the funct3 constants (LB..LHU, SB..SW) belong in package cpu_types.
REQ-034 Load lane select and extension are a combinational sub-module, load_extend (funct3, addr[1:0], rdata -> data).
REQ-035 Remaining logic: one FSM process, one counter, and capture registers.

Verification
REQ-036 SW 0xDEADBEEF @0x100, gnt same cycle -> be=1111, addr=0x100, mem_stall=0 throughout, single req cycle.
REQ-037 LB @0x103, gnt cycle 0, rvalid cycle 2 with rdata=0x80FF_FF7F -> mem_stall high cycles 0-1, load_data=0xFFFFFF80 in cycle 2; LBU same -> 0x00000080.
REQ-038 SH 0x1234 @0x102, gnt delayed 3 cycles -> be=1100, wdata=0x12341234, addr/be/wdata stable across all REQ cycles, stall lasts 3 cycles.
REQ-039 LW @0x101 -> misalign_err pulse, dbus_req=0, mem_stall=0; LH @0x102 -> no error.
REQ-040 MAX_WAIT=4, load granted but no rvalid -> bus_err on the 4th RESP cycle, stall released, FSM back in IDLE.
REQ-041 Reset asserted in RESP, then rvalid arrives -> FSM stays IDLE, load_data=0, no error pulses.
